// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, lane masks.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        end
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, store-data shift, load extraction/extension
// and misalignment detection. Mask and shifts use the naturally aligned offset.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [1:0]  w_off;
    logic [31:0] w_shift;

    always_comb begin
        o_misalign = 1'b0;
        w_off      = i_off;
        o_mask     = MASK_W;
        case (i_funct3[1:0])
            2'b00: begin
                o_mask = MASK_B << i_off;
            end
            2'b01: begin
                o_misalign = i_off[0];
                w_off      = {i_off[1], 1'b0};
                o_mask     = MASK_H << w_off;
            end
            default: begin
                o_misalign = |i_off;
                w_off      = 2'b00;
            end
        endcase

        o_wdata = i_wdata << {w_off, 3'b000};
        w_shift = i_rdata >> {w_off, 3'b000};

        case (i_funct3)
            LB:      o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            LH:      o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            LBU:     o_rdata = {24'd0, w_shift[7:0]};
            LHU:     o_rdata = {16'd0, w_shift[15:0]};
            default: o_rdata = w_shift;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one core request -> one ready/valid memory transaction -> one
// response pulse, with decode traps and a memory timeout trap.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int TIMEOUT       = 64,
    parameter int TRAP_MISALIGN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_trap,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_mask,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_trap;
    logic [31:0]       r_rsp_rdata;

    logic [2:0]        w_funct3;
    logic [1:0]        w_off;
    logic [3:0]        w_mask;
    logic [31:0]       w_wdata_sh;
    logic [31:0]       w_rdata_ext;
    logic              w_misalign;
    logic              w_decode_trap;
    logic              w_expire;
    logic              w_in_req;

    // Decode the live request while idle, the captured one afterwards.
    assign w_funct3 = (r_state == IDLE) ? i_req_funct3    : r_funct3;
    assign w_off    = (r_state == IDLE) ? i_req_addr[1:0] : r_addr[1:0];

    lsu_align u_align (
        .i_funct3   (w_funct3),
        .i_off      (w_off),
        .i_wdata    (r_wdata),
        .i_rdata    (i_mem_rdata),
        .o_mask     (w_mask),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign)
    );

    assign w_decode_trap = !f3_legal(i_req_we, i_req_funct3) ||
                           ((TRAP_MISALIGN != 0) && w_misalign);
    assign w_expire      = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_req_valid) w_state_next = w_decode_trap ? RESP : REQ;
            REQ: begin
                if (i_mem_ready)   w_state_next = r_we ? RESP : WAIT;
                else if (w_expire) w_state_next = RESP;
            end
            WAIT: if (i_mem_rvalid || w_expire) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_cnt       <= '0;
            r_rsp_trap  <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) && ((w_state_next == REQ) || (w_state_next == WAIT)))
                r_cnt <= '0;
            else if ((r_state == REQ) || (r_state == WAIT))
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we        <= i_req_we;
                        r_funct3    <= i_req_funct3;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_rsp_trap  <= w_decode_trap;
                        r_rsp_rdata <= 32'd0;
                    end
                end
                REQ: if (!i_mem_ready && w_expire) r_rsp_trap <= 1'b1;
                // Data wins over a coincident timeout expiry.
                WAIT: begin
                    if (i_mem_rvalid)  r_rsp_rdata <= w_rdata_ext;
                    else if (w_expire) r_rsp_trap  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_in_req    = (r_state == REQ);
    assign o_req_ready = (r_state == IDLE);
    assign o_mem_valid = w_in_req;
    assign o_mem_ren   = w_in_req && !r_we;
    assign o_mem_wen   = w_in_req && r_we;
    assign o_mem_addr  = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign o_mem_wdata = w_in_req ? w_wdata_sh : 32'd0;
    assign o_mem_mask  = w_in_req ? w_mask : 4'd0;
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_trap  = (r_state == RESP) && r_rsp_trap;
    assign o_rsp_rdata = (r_state == RESP) ? r_rsp_rdata : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of single transactions plus hand-written
// multi-cycle sequences (backpressure, timeout, rvalid at expiry, reset in flight).
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_trap;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_ren, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .TIMEOUT(8), .TRAP_MISALIGN(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_trap(rsp_trap),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
        .o_mem_mask(mem_mask), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic        trap;
        logic [31:0] maddr;
        logic [3:0]  mask;
        logic [31:0] wexp;
        logic [31:0] rexp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_trap"},  32'(rsp_trap),  32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata,      32'd0);
        check({tag, " mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, " mem_addr"},  mem_addr,       32'd0);
        check({tag, " mem_mask"},  32'(mem_mask),  32'd0);
        check({tag, " mem_wdata"}, mem_wdata,      32'd0);
        check({tag, " mem_ren/wen"}, 32'({mem_ren, mem_wen}), 32'd0);
    endtask

    // One transaction with an always-ready memory returning data the cycle after accept.
    task automatic run_vec(input int idx);
        vec_t v;
        int   cycles, lat, exp_lat;
        logic got, saw_mem, pend;
        logic [31:0] c_addr, c_wdata, c_rdata;
        logic [3:0]  c_mask;
        logic c_trap, c_ren, c_wen, c_rdy;
        v = vecs[idx];
        exp_lat = v.trap ? 1 : (v.we ? 2 : 3);
        got = 0; saw_mem = 0; pend = 0; cycles = 0; lat = 0;
        c_addr = 0; c_wdata = 0; c_rdata = 0; c_mask = 0; c_trap = 0;
        c_ren = 0; c_wen = 0; c_rdy = 0;
        start_req(v.we, v.f3, v.addr, v.wdata);
        while (!got && cycles < 20) begin
            if (mem_valid && !saw_mem) begin
                saw_mem = 1; c_addr = mem_addr; c_mask = mem_mask;
                c_wdata = mem_wdata; c_ren = mem_ren; c_wen = mem_wen;
            end
            if (rsp_valid) begin
                got = 1; lat = cycles + 1; c_rdata = rsp_rdata;
                c_trap = rsp_trap; c_rdy = req_ready;
            end
            mem_rvalid = pend;
            mem_rdata  = pend ? v.mdata : 32'h5A5A_5A5A;
            pend       = mem_valid && mem_ren;
            mem_ready  = mem_valid;
            tick();
            cycles++;
        end
        mem_ready = 0; mem_rvalid = 0;
        check($sformatf("v%0d rsp_seen", idx), 32'(got), 32'd1);
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat));
        check($sformatf("v%0d trap", idx), 32'(c_trap), 32'(v.trap));
        check($sformatf("v%0d rdata", idx), c_rdata, v.rexp);
        check($sformatf("v%0d req_ready_in_resp", idx), 32'(c_rdy), 32'd0);
        check($sformatf("v%0d mem_access", idx), 32'(saw_mem), 32'(!v.trap));
        if (!v.trap) begin
            check($sformatf("v%0d mem_addr", idx), c_addr, v.maddr);
            check($sformatf("v%0d mem_mask", idx), 32'(c_mask), 32'(v.mask));
            check($sformatf("v%0d ren/wen", idx), 32'({c_ren, c_wen}), 32'({!v.we, v.we}));
            if (v.we)
                check($sformatf("v%0d mem_wdata", idx), c_wdata & lanes(v.mask), v.wexp);
        end
        $display("vec %0d: we=%0d f3=%0d addr=0x%08h -> trap=%0d rdata=0x%08h lat=%0d",
                 idx, v.we, v.f3, v.addr, c_trap, c_rdata, lat);
    endtask

    initial begin
        int n;
        logic [31:0] a0;
        logic [3:0]  m0;
        //          we  f3     addr           wdata          mdata          trap maddr          mask     wexp           rexp
        vecs[0]  = '{1, SB,  32'h0000_2003, 32'h0000_00AB, 32'h0,         0, 32'h0000_2000, 4'b1000, 32'hAB00_0000, 32'h0};
        vecs[1]  = '{0, LH,  32'h0000_1002, 32'h0,         32'h8001_1234, 0, 32'h0000_1000, 4'b1100, 32'h0,         32'hFFFF_8001};
        vecs[2]  = '{0, LHU, 32'h0000_1002, 32'h0,         32'h8001_1234, 0, 32'h0000_1000, 4'b1100, 32'h0,         32'h0000_8001};
        vecs[3]  = '{0, LW,  32'h0000_1001, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[4]  = '{0, 3'b011, 32'h0000_1000, 32'h0,      32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[5]  = '{0, LB,  32'h0000_3001, 32'h0,         32'h1234_8056, 0, 32'h0000_3000, 4'b0010, 32'h0,         32'hFFFF_FF80};
        vecs[6]  = '{0, LBU, 32'h0000_3003, 32'h0,         32'hF100_0000, 0, 32'h0000_3000, 4'b1000, 32'h0,         32'h0000_00F1};
        vecs[7]  = '{1, SH,  32'h0000_4002, 32'h1234_BEEF, 32'h0,         0, 32'h0000_4000, 4'b1100, 32'hBEEF_0000, 32'h0};
        vecs[8]  = '{1, SW,  32'h0000_4000, 32'hCAFE_F00D, 32'h0,         0, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1, 3'b100, 32'h0000_4000, 32'h1,      32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[10] = '{1, SH,  32'h0000_4001, 32'h1,         32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[11] = '{0, LW,  32'h0000_5000, 32'h0,         32'h89AB_CDEF, 0, 32'h0000_5000, 4'b1111, 32'h0,         32'h89AB_CDEF};
        vecs[12] = '{0, LB,  32'h0000_3000, 32'h0,         32'hFFFF_FF7F, 0, 32'h0000_3000, 4'b0001, 32'h0,         32'h0000_007F};

        rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) tick();
        rst = 0;
        check_idle_outputs("reset");
        $display("reset: req_ready=%0d mem_valid=%0d rsp_valid=%0d", req_ready, mem_valid, rsp_valid);

        for (int i = 0; i < 13; i++) begin
            run_vec(i);
            tick();
        end

        // Load held in REQ for 5 cycles, then rvalid on the third WAIT cycle.
        start_req(0, LW, 32'h0000_6000, 32'h0);
        a0 = mem_addr; m0 = mem_mask;
        check("bp first addr", a0, 32'h0000_6000);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp valid c%0d", i), 32'(mem_valid), 32'd1);
            check($sformatf("bp addr c%0d", i), mem_addr, a0);
            check($sformatf("bp mask c%0d", i), 32'(mem_mask), 32'(m0));
            check($sformatf("bp req_ready c%0d", i), 32'(req_ready), 32'd0);
            mem_ready = (i == 5);
            tick();
        end
        mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("bp wait rsp c%0d", i), 32'(rsp_valid), 32'd0);
            check($sformatf("bp wait req_ready c%0d", i), 32'(req_ready), 32'd0);
            tick();
        end
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        check("bp rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("bp rsp_trap", 32'(rsp_trap), 32'd0);
        $display("backpressure load: rdata=0x%08h trap=%0d", rsp_rdata, rsp_trap);
        tick();

        // Memory never returns data: timeout trap after 8 WAIT cycles.
        start_req(0, LW, 32'h0000_7000, 32'h0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        check("to wait_cycles", 32'(n), 32'd8);
        check("to rsp_trap", 32'(rsp_trap), 32'd1);
        check("to rsp_rdata", rsp_rdata, 32'd0);
        $display("timeout load: cycles=%0d trap=%0d rdata=0x%08h", n, rsp_trap, rsp_rdata);
        tick();
        run_vec(0);
        tick();

        // rvalid on the expiry cycle is data, not a trap.
        start_req(0, LBU, 32'h0000_7101, 32'h0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        repeat (7) tick();
        mem_rvalid = 1; mem_rdata = 32'h1357_9BDF;
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        check("expiry rsp_valid", 32'(rsp_valid), 32'd1);
        check("expiry rsp_trap", 32'(rsp_trap), 32'd0);
        check("expiry rsp_rdata", rsp_rdata, 32'h0000_009B);
        $display("rvalid at expiry: trap=%0d rdata=0x%08h", rsp_trap, rsp_rdata);
        tick();

        // Reset while waiting for data; a late rvalid must not produce a response.
        start_req(0, LW, 32'h0000_7200, 32'h0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 0; mem_rdata = 0;
        for (int i = 0; i < 3; i++) begin
            check_idle_outputs($sformatf("rst_mid c%0d", i));
            tick();
        end
        $display("reset in WAIT: req_ready=%0d rsp_valid=%0d", req_ready, rsp_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit that replaces the hart's fixed combinational, word-only dmem hookup.
- Takes one load or store request from the core and computes byte/half/word masks and lane shifts.
- Runs a ready/valid transaction against a variable-latency data memory and returns one response per request.
- Sign/zero extension, misalignment trap and memory timeout trap are built in. Sits between the hart's execute stage and dmem.

Parameters:
- ADDR_W, 32, byte-address width of the core and memory address ports.
- TIMEOUT, 64, max cycles waiting for i_mem_ready or i_mem_rvalid before a trap response. 0 disables the timeout.
- TRAP_MISALIGN, 1, 1 = misaligned access traps without a memory access; 0 = access proceeds with the address forced to natural alignment.

Ports:
- i_clk in 1 global clock
- i_rst in 1 synchronous active-high reset
- i_req_valid in 1 core request valid
- o_req_ready out 1 unit can accept a request
- i_req_we in 1 1 = store, 0 = load
- i_req_funct3 in 3 RISC-V funct3 of the load/store
- i_req_addr in ADDR_W byte address
- i_req_wdata in 32 store data, LSB-justified
- o_rsp_valid out 1 one-cycle response pulse
- o_rsp_rdata out 32 extended load result (0 for stores and traps)
- o_rsp_trap out 1 response is a trap
- o_mem_valid out 1 memory request valid
- i_mem_ready in 1 memory accepts request
- o_mem_addr out ADDR_W word-aligned address, low 2 bits zero
- o_mem_ren out 1 read request
- o_mem_wen out 1 write request
- o_mem_wdata out 32 lane-shifted store data
- o_mem_mask out 4 byte-lane mask
- i_mem_rvalid in 1 read data valid
- i_mem_rdata in 32 read word

Behaviour:
- Reset: state IDLE, o_req_ready=1. All other outputs 0, timeout counter 0.
- FSM states and transitions:
  - IDLE: o_req_ready=1. On i_req_valid, capture the request and decode it.
    - Illegal funct3 (load: 000/001/010/100/101 legal; store: 000/001/010 legal) goes to RESP with trap.
    - Misaligned access with TRAP_MISALIGN=1 goes to RESP with trap; o_mem_valid is never asserted.
    - Otherwise go to REQ.
  - REQ: o_mem_valid=1, exactly one of ren/wen set. addr, wdata and mask are held stable until i_mem_ready.
    - On accept: a store goes to RESP; a load goes to WAIT.
  - WAIT: on i_mem_rvalid, register the extended data and go to RESP. i_mem_rvalid in any other state is ignored.
  - RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Misalignment rules: half-word with addr[0]=1; word with addr[1:0]!=0.
- Mask by funct3[1:0] and offset off=addr[1:0]:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- o_mem_wdata = i_req_wdata << (8*off); unmasked lanes are don't-care.
- Load extraction: shift i_mem_rdata right by 8*off. Sign-extend for funct3 000/001, zero-extend for 100/101. Word loads pass through.
- Timeout: the counter clears on entering REQ or WAIT and increments each cycle spent in those states.
  - On reaching TIMEOUT: deassert o_mem_valid, go to RESP with trap, rdata=0.
- Latency, request accepted at edge N:
  - Store with i_mem_ready=1: o_mem_valid in cycle N+1, o_rsp_valid in N+2.
  - Load with ready=1 and rvalid in the cycle after accept: response in N+3.
  - Trap on decode: response in N+1.
- Simultaneous events: rvalid in the same cycle as the timeout expiry is treated as data (no trap). A new request is only accepted in IDLE, so a request coincident with o_rsp_valid waits one cycle.
- Reset mid-operation: return to IDLE next edge, drop the in-flight transaction, emit no response. A late rvalid after reset is ignored.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - state enum (IDLE, REQ, WAIT, RESP)
  - mask constants
- One combinational sub-module, lsu_align: funct3 + offset + data in; mask, shifted wdata, extended rdata and misalign flag out. Reused later by the pipelined hart.
- The FSM and timeout counter stay in lsu.

Test Plan:
- SB addr 0x2003, wdata 0x000000AB, ready=1 → o_mem_addr 0x2000, mask 4'b1000, wdata[31:24]=0xAB, rsp trap=0 two cycles after accept.
- LH addr 0x1002, rdata 0x8001_1234 → rsp_rdata 0xFFFF8001; LHU same → 0x00008001.
- LW addr 0x1001, TRAP_MISALIGN=1 → rsp trap=1 next cycle, o_mem_valid never asserted; funct3 011 load → trap.
- LW with i_mem_ready low for 5 cycles, rvalid 3 cycles later with 0xDEADBEEF → o_mem_valid held with stable addr/mask, rsp_rdata 0xDEADBEEF, o_req_ready low throughout.
- TIMEOUT=8, memory never responds → o_rsp_trap=1, rsp_rdata=0 after 8 cycles in WAIT; next request accepted normally.
- Assert i_rst during WAIT, then drive rvalid → no o_rsp_valid, all outputs at reset values, o_req_ready=1.
